// File: rtl/serial_add_arb.sv
// serial_add_arb: two-requester arbiter sharing one full-adder cell for bit-serial WIDTH-bit addition
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c;
    assign c_out = (a & b) | (c & (a ^ b));
endmodule

module serial_add_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]       state;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             carry, last, g, s, co, accept;
    // last holds the previously served requester; on contention the other one wins
    assign g          = (req0_valid & req1_valid) ? ~last : req1_valid;
    assign req0_ready = (state == IDLE) & req0_valid & ~g;
    assign req1_ready = (state == IDLE) & req1_valid & g;
    assign accept     = req0_ready | req1_ready;
    assign res_valid  = state == DONE;
    assign busy       = state != IDLE;
    fulladder u_fa (.a(sa[0]), .b(sb[0]), .c(carry), .s(s), .c_out(co));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            carry    <= 1'b0;
            last     <= 1'b1;
            cnt      <= '0;
            res_id   <= 1'b0;
            res_sum  <= '0;
            res_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sa     <= g ? req1_a : req0_a;
                    sb     <= g ? req1_b : req0_b;
                    carry  <= g ? req1_cin : req0_cin;
                    cnt    <= '0;
                    res_id <= g;
                    state  <= RUN;
                end
                RUN: begin
                    sa      <= sa >> 1;
                    sb      <= sb >> 1;
                    carry   <= co;
                    res_sum <= {s, res_sum[WIDTH-1:1]};
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        res_cout <= co;
                        state    <= DONE;
                    end
                end
                DONE: if (res_ready) begin
                    last  <= res_id;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
